id_ex_pipe_stage: RTL and testbench

//  ID->EX pipeline register of the MIPS datapath, directly downstream of the decode control unit.

---
 rtl/mips_pkg.sv | 39 +++
 rtl/load_use_hazard.sv | 28 ++
 rtl/id_ex_pipe_stage.sv | 130 +++++++++++++
 tb/tb_id_ex_pipe_stage.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: opcodes, ALUOp encodings and the
// layout of the decode control word handed from ID to EX.
package mips_pkg;

  // Control word width and field positions
  localparam int CTRL_W        = 12;
  localparam int CTRL_REGDST   = 11;
  localparam int CTRL_ALUSRC   = 10;
  localparam int CTRL_MEMTOREG = 9;
  localparam int CTRL_REGWRITE = 8;
  localparam int CTRL_MEMREAD  = 7;
  localparam int CTRL_MEMWRITE = 6;
  localparam int CTRL_BRANCH   = 5;
  localparam int CTRL_JUMP     = 4;
  localparam int CTRL_SIGNZERO = 3;
  localparam int CTRL_ALUOP_HI = 2;
  localparam int CTRL_ALUOP_LO = 1;

  // Opcodes understood by the decode unit
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_J     = 6'h02;

  // ALUOp encodings
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;
  localparam logic [1:0] ALUOP_XOR  = 2'b11;

  // An instruction consumes its rt register as a source when it is an
  // R-type (RegDst), a store (MemWrite) or a compare-branch (Branch).
  function automatic logic ctrl_reads_rt(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_REGDST] | ctrl[CTRL_MEMWRITE] | ctrl[CTRL_BRANCH];
  endfunction

endpackage

// File: rtl/load_use_hazard.sv
// Load-use hazard detector: flags an ID instruction that needs a register
// the load currently in EX has not yet fetched from memory.
module load_use_hazard
  import mips_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              id_valid,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              haz
);

  // Compare the load destination with the ID sources; $zero never stalls
  always_comb begin
    haz = 1'b0;
    if (ex_valid && ex_mem_read && id_valid && (ex_rt != {REG_AW{1'b0}})) begin
      haz = (ex_rt == id_rs) | ((ex_rt == id_rt) & id_rt_used);
    end else begin
      haz = 1'b0;
    end
  end

endmodule

// File: rtl/id_ex_pipe_stage.sv
// ID->EX pipeline register. Captures the decoded control word, operands
// and register indices, inserts a single bubble on a load-use hazard,
// honours branch flush and downstream hold, and counts hazard bubbles.
module id_ex_pipe_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              id_hold,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CTRL_W-1:0] CTRL_NOP = {CTRL_W{1'b0}};

  logic haz;
  logic id_rt_used;
  logic take_bubble;
  logic count_bubble;

  assign id_rt_used = ctrl_reads_rt(id_ctrl);

  load_use_hazard #(
    .REG_AW (REG_AW)
  ) u_load_use_hazard (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl[CTRL_MEMREAD]),
    .ex_rt       (ex_rt),
    .id_valid    (id_valid),
    .id_rt_used  (id_rt_used),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .haz         (haz)
  );

  // Stall request to PC/IF-ID: a flush already kills the ID instruction,
  // so a hazard alongside it must not freeze the front end
  always_comb begin
    id_hold = 1'b0;
    if (reset) begin
      id_hold = 1'b0;
    end else begin
      id_hold = ex_hold | (haz & ~flush);
    end
  end

  // Decide what the next edge loads: hold beats flush beats hazard
  always_comb begin
    take_bubble  = 1'b0;
    count_bubble = 1'b0;
    if (ex_hold) begin
      take_bubble  = 1'b0;
      count_bubble = 1'b0;
    end else if (flush) begin
      take_bubble  = 1'b1;
      count_bubble = 1'b0;
    end else if (haz) begin
      take_bubble  = 1'b1;
      count_bubble = 1'b1;
    end else begin
      take_bubble  = 1'b0;
      count_bubble = 1'b0;
    end
  end

  // Pipeline register; a bubble zeroes valid and the whole control word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= CTRL_NOP;
      ex_rs    <= {REG_AW{1'b0}};
      ex_rt    <= {REG_AW{1'b0}};
      ex_rd    <= {REG_AW{1'b0}};
      ex_rd1   <= {DATA_W{1'b0}};
      ex_rd2   <= {DATA_W{1'b0}};
      ex_imm   <= {DATA_W{1'b0}};
      ex_pc4   <= {DATA_W{1'b0}};
    end else if (!ex_hold) begin
      ex_rs  <= id_rs;
      ex_rt  <= id_rt;
      ex_rd  <= id_rd;
      ex_rd1 <= id_rd1;
      ex_rd2 <= id_rd2;
      ex_imm <= id_imm;
      ex_pc4 <= id_pc4;
      if (take_bubble) begin
        ex_valid <= 1'b0;
        ex_ctrl  <= CTRL_NOP;
      end else begin
        ex_valid <= id_valid;
        ex_ctrl  <= id_valid ? id_ctrl : CTRL_NOP;
      end
    end
  end

  // Saturating count of hazard bubbles (flush bubbles are not counted)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt <= {CNT_W{1'b0}};
    end else if (count_bubble && (bubble_cnt != CNT_MAX)) begin
      bubble_cnt <= bubble_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Testbench for id_ex_pipe_stage: directed MIPS load-use scenarios followed
// by randomized traffic, checked against an instruction-level model.
module tb_id_ex_pipe_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  // instruction kinds used by the model
  localparam int I_NONE  = -1;
  localparam int I_RTYPE = 0;
  localparam int I_LW    = 1;
  localparam int I_SW    = 2;
  localparam int I_BNE   = 3;
  localparam int I_XORI  = 4;
  localparam int I_J     = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          id_valid;
  logic [11:0]   id_ctrl;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic [DW-1:0] id_rd1, id_rd2, id_imm, id_pc4;
  logic          flush, ex_hold;

  logic          id_hold, ex_valid;
  logic [11:0]   ex_ctrl;
  logic [AW-1:0] ex_rs, ex_rt, ex_rd;
  logic [DW-1:0] ex_rd1, ex_rd2, ex_imm, ex_pc4;
  logic [15:0]   bubble_cnt;

  logic          s_id_hold, s_ex_valid;
  logic [11:0]   s_ex_ctrl;
  logic [AW-1:0] s_ex_rs, s_ex_rt, s_ex_rd;
  logic [DW-1:0] s_ex_rd1, s_ex_rd2, s_ex_imm, s_ex_pc4;
  logic [1:0]    s_bubble_cnt;

  id_ex_pipe_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_pc4(id_pc4), .flush(flush), .ex_hold(ex_hold),
    .id_hold(id_hold), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_imm(ex_imm), .ex_pc4(ex_pc4), .bubble_cnt(bubble_cnt)
  );

  // narrow-counter copy fed the same stream, to reach saturation quickly
  id_ex_pipe_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_pc4(id_pc4), .flush(flush), .ex_hold(ex_hold),
    .id_hold(s_id_hold), .ex_valid(s_ex_valid), .ex_ctrl(s_ex_ctrl),
    .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_rd(s_ex_rd), .ex_rd1(s_ex_rd1), .ex_rd2(s_ex_rd2),
    .ex_imm(s_ex_imm), .ex_pc4(s_ex_pc4), .bubble_cnt(s_bubble_cnt)
  );

  int checks   = 0;
  int failures = 0;

  // model state: which instruction sits in EX and its fields
  int            cur_op;
  bit            m_valid;
  int            m_op;
  logic [11:0]   m_ctrl;
  logic [AW-1:0] m_rs, m_rt, m_rd;
  logic [DW-1:0] m_rd1, m_rd2, m_imm, m_pc4;
  bit            m_dk;
  int            n_haz;
  bit            m_hold;
  logic          s_hold_obs;

  function automatic logic [11:0] ctrl_of(input int op);
    case (op)
      I_RTYPE: return 12'h904;
      I_LW:    return 12'h780;
      I_SW:    return 12'h440;
      I_BNE:   return 12'h022;
      I_XORI:  return 12'h50E;
      I_J:     return 12'h010;
      default: return 12'h000;
    endcase
  endfunction

  function automatic bit reads_rt(input int op);
    return (op == I_RTYPE) || (op == I_SW) || (op == I_BNE);
  endfunction

  function automatic int sat(input int n, input int mx);
    return (n > mx) ? mx : n;
  endfunction

  function automatic bit model_haz();
    return m_valid && (m_op == I_LW) && (m_rt != 5'd0) && (id_valid === 1'b1) &&
           ((m_rt == id_rs) || ((m_rt == id_rt) && reads_rt(cur_op)));
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_valid = 1'b0; m_op = I_NONE; m_ctrl = 12'h000;
    m_rs = 5'd0; m_rt = 5'd0; m_rd = 5'd0;
    m_rd1 = 32'd0; m_rd2 = 32'd0; m_imm = 32'd0; m_pc4 = 32'd0;
    m_dk = 1'b1; n_haz = 0; m_hold = 1'b0;
  endtask

  task automatic model_load_data();
    m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
    m_rd1 = id_rd1; m_rd2 = id_rd2; m_imm = id_imm; m_pc4 = id_pc4;
    m_dk = 1'b1;
  endtask

  task automatic check_outputs();
    logic [15:0] exp_cnt;
    logic [1:0]  exp_cnt_s;
    exp_cnt   = 16'(sat(n_haz, 65535));
    exp_cnt_s = 2'(sat(n_haz, 3));
    chk("ex_valid", ex_valid, m_valid);
    chk("ex_ctrl", ex_ctrl, m_ctrl);
    chk("bubble_cnt", bubble_cnt, exp_cnt);
    chk("bubble_cnt_small", s_bubble_cnt, exp_cnt_s);
    if (m_dk) begin
      chk("ex_fields", {ex_rs, ex_rt, ex_rd, ex_rd1, ex_rd2, ex_imm, ex_pc4},
          {m_rs, m_rt, m_rd, m_rd1, m_rd2, m_imm, m_pc4});
    end
  endtask

  task automatic set_instr(input int op, input int rs, input int rt, input int rd);
    cur_op  = op;
    id_ctrl = ctrl_of(op);
    id_rs   = 5'(rs);
    id_rt   = 5'(rt);
    id_rd   = 5'(rd);
    id_rd1  = $urandom;
    id_rd2  = $urandom;
    id_imm  = $urandom;
    id_pc4  = $urandom;
  endtask

  // one cycle: drive at negedge, check id_hold, advance model at posedge, check EX
  task automatic step(input bit valid, input bit fl, input bit hd);
    bit h;
    @(negedge clk);
    id_valid = valid; flush = fl; ex_hold = hd;
    #1;
    h = model_haz();
    m_hold = hd | (h & ~fl);
    s_hold_obs = id_hold;
    chk("id_hold", id_hold, m_hold);
    @(posedge clk);
    if (!hd) begin
      if (fl) begin
        m_valid = 1'b0; m_op = I_NONE; m_ctrl = 12'h000;
        model_load_data();
      end else if (h) begin
        m_valid = 1'b0; m_op = I_NONE; m_ctrl = 12'h000;
        m_dk = 1'b0;
        n_haz++;
      end else begin
        m_valid = valid;
        m_op    = valid ? cur_op : I_NONE;
        m_ctrl  = valid ? ctrl_of(cur_op) : 12'h000;
        model_load_data();
      end
    end
    #1;
    check_outputs();
  endtask

  initial begin
    // reset state; id_hold must stay low under reset even with ex_hold
    reset = 1'b1; id_valid = 1'b0; flush = 1'b0; ex_hold = 1'b1;
    set_instr(I_NONE, 0, 0, 0);
    model_clear();
    #3;
    chk("reset_id_hold", id_hold, 1'b0);
    check_outputs();
    @(negedge clk);
    reset = 1'b0; ex_hold = 1'b0;

    // lw $t0,0($t1) ; add $t1,$t0,$t2 -> one bubble
    set_instr(I_LW, 9, 8, 0);      step(1'b1, 1'b0, 1'b0);
    set_instr(I_RTYPE, 8, 10, 9);  step(1'b1, 1'b0, 1'b0);
    chk("t1_stall", s_hold_obs, 1'b1);
    chk("t1_bubble_ctrl", ex_ctrl, 12'h000);
    chk("t1_cnt", bubble_cnt, 16'd1);
    step(1'b1, 1'b0, 1'b0);
    chk("t1_no_second_stall", s_hold_obs, 1'b0);
    chk("t1_add_in_ex", ex_ctrl, 12'h904);

    // lw $t0 ; add $t1,$t2,$t3 -> independent, back to back
    set_instr(I_LW, 9, 8, 0);      step(1'b1, 1'b0, 1'b0);
    set_instr(I_RTYPE, 10, 11, 9); step(1'b1, 1'b0, 1'b0);
    chk("t2_no_stall", s_hold_obs, 1'b0);
    chk("t2_cnt", bubble_cnt, 16'd1);

    // lw $zero ; use of $zero -> no stall
    set_instr(I_LW, 9, 0, 0);      step(1'b1, 1'b0, 1'b0);
    set_instr(I_RTYPE, 0, 0, 9);   step(1'b1, 1'b0, 1'b0);
    chk("t3_zero_no_stall", s_hold_obs, 1'b0);

    // lw $t0 ; sw $t0,0($t1) -> stall through rt
    set_instr(I_LW, 9, 8, 0);      step(1'b1, 1'b0, 1'b0);
    set_instr(I_SW, 9, 8, 0);      step(1'b1, 1'b0, 1'b0);
    chk("t4_sw_stall", s_hold_obs, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    // lw $t0 ; xori $t0,$t1,5 -> rt is a destination, no stall
    set_instr(I_LW, 9, 8, 0);      step(1'b1, 1'b0, 1'b0);
    set_instr(I_XORI, 9, 8, 0);    step(1'b1, 1'b0, 1'b0);
    chk("t4_xori_no_stall", s_hold_obs, 1'b0);

    // flush together with a hazard: bubble, no hold, count unchanged
    set_instr(I_LW, 9, 8, 0);      step(1'b1, 1'b0, 1'b0);
    set_instr(I_RTYPE, 8, 10, 9);  step(1'b1, 1'b1, 1'b0);
    chk("t5_flush_no_hold", s_hold_obs, 1'b0);
    chk("t5_flush_invalid", ex_valid, 1'b0);
    chk("t5_flush_cnt", bubble_cnt, 16'd2);

    // ex_hold for three cycles with flush pulsed: EX frozen, id_hold high
    set_instr(I_LW, 9, 8, 0);      step(1'b1, 1'b0, 1'b0);
    set_instr(I_RTYPE, 8, 10, 9);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("t6_hold_flush", s_hold_obs, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("t6_frozen_ctrl", ex_ctrl, 12'h780);

    // reset asserted mid-stall clears everything asynchronously
    @(negedge clk);
    id_valid = 1'b1; flush = 1'b0; ex_hold = 1'b0;
    #1;
    chk("t6_pre_reset_stall", id_hold, 1'b1);
    #2 reset = 1'b1;
    #1;
    model_clear();
    chk("t6_reset_hold_low", id_hold, 1'b0);
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    chk("t6_release_load", ex_ctrl, 12'h904);

    // five back-to-back load-use pairs: narrow counter saturates at 3
    for (int k = 0; k < 5; k++) begin
      set_instr(I_LW, 9, 8, 0);     step(1'b1, 1'b0, 1'b0);
      set_instr(I_BNE, 11, 8, 0);   step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
    end
    chk("sat_small", s_bubble_cnt, 2'd3);
    chk("sat_wide", bubble_cnt, 16'd5);

    // randomized traffic; IF/ID re-presents the same instruction while held
    for (int i = 0; i < 800; i++) begin
      if (!m_hold) begin
        set_instr(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
      step($urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
